regfile_write_scheduler: RTL and testbench
==========================================

# regfile_write_scheduler

Sequences and shares the single write port of the 32-entry register file. After reset it sweeps every register to zero, then grants the write port round-robin among `NumReq` writeback requesters (e.g. ALU, load unit, CSR unit) with a valid/ready handshake. It sits between the core's writeback sources and the register file's `in_write_enable` / `in_write_register_select` / `in_write_data` inputs. Writes to x0 are accepted but never forwarded.

## Interface

Parameters:
- `DataSz`, 32, MSB index of data; data words are `DataSz+1` bits wide, matching the register file.
- `NumReq`, 3, number of writeback requesters; must be 2–8.
- `num_registers`, 32, registers cleared by the init sweep; must be ≤ 32.

Ports:
- `CLK`  in  1  single clock; all state on posedge.
- `RESET`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `NumReq`  requester i has a write pending.
- `req_select`  in  `5*NumReq`  destination register of requester i, in bits [5i+4:5i].
- `req_data`  in  `(DataSz+1)*NumReq`  write data of requester i, in slice i.
- `req_ready`  out  `NumReq`  one-hot grant; a transfer occurs when `req_valid[i] && req_ready[i]`.
- `out_write_enable`  out  1  drives the register file's `in_write_enable`.
- `out_write_register_select`  out  5  drives `in_write_register_select`.
- `out_write_data`  out  `DataSz+1`  drives `in_write_data`.
- `out_init_done`  out  1  high once the zeroing sweep has completed.

## Operation

- States: INIT and RUN. Reset enters INIT.
- INIT:
  - Counter `idx` starts at 0 and increments each cycle.
  - Each cycle the registered outputs are loaded with `enable=1`, `select=idx`, `data=0`.
  - `req_ready` is 0 throughout INIT.
  - When `idx == num_registers-1` has been issued, go to RUN and set `out_init_done` to 1. It stays 1 until the next reset.
- RUN arbitration:
  - `req_ready` is combinational from `req_valid` and a round-robin pointer `rr` (0..NumReq-1).
  - Grant the first valid requester searching upward from `rr` and wrapping modulo `NumReq`.
  - At most one ready bit is high. All ready bits are 0 when no request is valid.
- On a transfer by requester g:
  - `rr` becomes (g+1) mod `NumReq`.
  - The output registers capture `select = req_select[g]` and `data = req_data[g]`.
  - `enable` is 1, unless `req_select[g] == 0`. An x0 write is accepted and consumed, but `enable` is 0.
- With no transfer, `enable` is 0 the next cycle. `select` and `data` hold their previous values.
- `rr` changes only on a transfer.
- Requesters must hold `valid`, `select` and `data` stable until ready. Dropping `valid` before ready is legal; the request is simply withdrawn.
- No ordering or hazard checking between requesters. Consumers must not issue two writes to the same register in flight if order matters.

## Timing

- Reset values, asserted asynchronously:
  - `out_write_enable` = 0, `out_write_register_select` = 0, `out_write_data` = 0.
  - `out_init_done` = 0, `req_ready` = 0.
  - `rr` = 0, `idx` = 0, state INIT.
- First posedge after `RESET` falls: the outputs present the write for register 0. Register k's write is presented after edge k+1.
- The register file commits register k at edge k+2. The last register is committed at edge `num_registers`+1.
- `out_init_done` rises at the same edge that presents the write of register `num_registers-1`. `req_ready` can therefore first assert during that cycle.
- RUN throughput: one write per cycle; back-to-back transfers are allowed.
- Latency:
  - Transfer at edge N → `out_write_enable` is high from N to N+1.
  - The register file commits at edge N+1.
- Reset mid-INIT or mid-RUN:
  - Immediately forces the reset values and drops any in-flight write (`out_write_enable` goes to 0 asynchronously).
  - The sweep restarts at register 0.
- Simultaneous valid on all requesters: strict rotation 0,1,2,0,… with `rr` starting at 0.

## Test plan

- Init sweep:
  - Stimulus: deassert `RESET` with no requests.
  - Required: exactly 32 cycles with `enable=1`, `select` = 0..31 in order, `data=0`; `out_init_done` high from the 32nd; all registers read 0.
- Single write:
  - Stimulus: after init, requester 1 writes 0x1234_5678 to x7.
  - Required: `req_ready` = 3'b010 the same cycle; next cycle `enable=1`, `select=7`, `data=0x12345678`; x7 then reads 0x12345678.
- Round-robin fairness:
  - Stimulus: all three requesters valid for 6 cycles, each targeting a distinct register.
  - Required: grants in order 0,1,2,0,1,2; no idle cycle.
- x0 suppression:
  - Stimulus: requester 2 writes 0xFFFF to x0.
  - Required: handshake completes; `out_write_enable` stays 0; x0 still reads 0; `rr` advances to 0.
- Reset mid-operation:
  - Stimulus: assert `RESET` in cycle 10 of INIT, and separately in a RUN cycle right after a transfer.
  - Required: `out_write_enable` drops without waiting for a clock edge; after release the sweep restarts at x0 and the dropped write never commits.
- Withdrawn request:
  - Stimulus: requester 0 drops `valid` while requester 1 is being granted.
  - Required: no spurious write for requester 0; the next grant follows `rr`.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// Register-file write-port scheduler: zeroing sweep after reset, then a
// round-robin valid/ready grant among NumReq writeback sources.
module regfile_write_scheduler #(
  parameter int DataSz        = 32,
  parameter int NumReq        = 3,
  parameter int num_registers = 32
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [NumReq-1:0]               req_valid,
  input  logic [5*NumReq-1:0]             req_select,
  input  logic [(DataSz+1)*NumReq-1:0]    req_data,
  output logic [NumReq-1:0]               req_ready,
  output logic                            out_write_enable,
  output logic [4:0]                      out_write_register_select,
  output logic [DataSz:0]                 out_write_data,
  output logic                            out_init_done
);

  localparam int RrW = $clog2(NumReq);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [4:0]     LastIdx = 5'(num_registers - 1);
  localparam logic [RrW-1:0] LastReq = RrW'(NumReq - 1);

  logic [0:0]      r_state;
  logic [4:0]      r_idx;
  logic [RrW-1:0]  r_rr;
  logic            r_we;
  logic [4:0]      r_sel;
  logic [DataSz:0] r_data;
  logic            r_init_done;

  logic [NumReq-1:0] w_grant;
  logic              w_found;
  logic [RrW-1:0]    w_gidx;
  int                w_cand;
  logic [4:0]        w_sel;
  logic [DataSz:0]   w_data;
  logic [RrW-1:0]    w_rr_next;

  // First valid requester at or above rr, wrapping; nothing is granted in INIT.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = 0;
    for (int k = 0; k < NumReq; k++) begin
      w_cand = int'(r_rr) + k;
      if (w_cand >= NumReq) w_cand = w_cand - NumReq;
      if (r_state == ST_RUN && !w_found && req_valid[w_cand]) begin
        w_found         = 1'b1;
        w_gidx          = RrW'(w_cand);
        w_grant[w_cand] = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel     = req_select[5*int'(w_gidx) +: 5];
    w_data    = req_data[(DataSz+1)*int'(w_gidx) +: (DataSz+1)];
    w_rr_next = (w_gidx == LastReq) ? '0 : w_gidx + RrW'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_INIT;
      r_idx       <= '0;
      r_rr        <= '0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_data      <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_we   <= 1'b1;
          r_sel  <= r_idx;
          r_data <= '0;
          r_idx  <= r_idx + 5'd1;
          if (r_idx == LastIdx) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        default: begin
          if (w_found) begin
            // x0 writes complete the handshake but never reach the file
            r_we   <= (w_sel != 5'd0);
            r_sel  <= w_sel;
            r_data <= w_data;
            r_rr   <= w_rr_next;
          end else begin
            r_we <= 1'b0;
          end
        end
      endcase
    end
  end

  assign req_ready                 = w_grant;
  assign out_write_enable          = r_we;
  assign out_write_register_select = r_sel;
  assign out_write_data            = r_data;
  assign out_init_done             = r_init_done;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: a transaction-level model plus
// a register-file image fed from the DUT write port, checked every cycle.
module tb_regfile_write_scheduler;

  localparam int NREQ = 3;
  localparam int NREG = 32;
  localparam int DW   = 33;

  logic                 CLK;
  logic                 RESET;
  logic [NREQ-1:0]      req_valid;
  logic [5*NREQ-1:0]    req_select;
  logic [DW*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 out_write_enable;
  logic [4:0]           out_write_register_select;
  logic [DW-1:0]        out_write_data;
  logic                 out_init_done;

  regfile_write_scheduler #(.DataSz(32), .NumReq(NREQ), .num_registers(NREG)) dut (
    .CLK                       (CLK),
    .RESET                     (RESET),
    .req_valid                 (req_valid),
    .req_select                (req_select),
    .req_data                  (req_data),
    .req_ready                 (req_ready),
    .out_write_enable          (out_write_enable),
    .out_write_register_select (out_write_register_select),
    .out_write_data            (out_write_data),
    .out_init_done             (out_init_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: how many sweep writes issued, whether init is over, rotation pointer.
  int            m_cnt  = 0;
  bit            m_done = 1'b0;
  int            m_rr   = 0;
  bit            m_we   = 1'b0;
  logic [4:0]    m_sel  = '0;
  logic [DW-1:0] m_data = '0;

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++)
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    g = pick(req_valid, m_rr);
    if (!m_done || g < 0) return '0;
    return NREQ'(1) << g;
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_cnt <= 0; m_done <= 1'b0; m_rr <= 0;
      m_we <= 1'b0; m_sel <= '0; m_data <= '0;
    end else if (!m_done) begin
      m_we   <= 1'b1;
      m_sel  <= 5'(m_cnt);
      m_data <= '0;
      m_cnt  <= m_cnt + 1;
      if (m_cnt == NREG - 1) m_done <= 1'b1;
    end else if (pick(req_valid, m_rr) >= 0) begin
      m_sel  <= req_select[5*pick(req_valid, m_rr) +: 5];
      m_data <= req_data[DW*pick(req_valid, m_rr) +: DW];
      m_we   <= (req_select[5*pick(req_valid, m_rr) +: 5] != 5'd0);
      m_rr   <= (pick(req_valid, m_rr) + 1) % NREQ;
    end else begin
      m_we <= 1'b0;
    end
  end

  // Register-file image: one from the DUT port, one from the model.
  logic [DW-1:0] rf     [NREG];
  logic [DW-1:0] exp_rf [NREG];

  always @(posedge CLK) begin
    if (out_write_enable) rf[out_write_register_select] <= out_write_data;
    if (m_we && !RESET) exp_rf[m_sel] <= m_data;
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("ready",   64'(req_ready),                 64'(exp_ready()));
      chk("enable",  64'(out_write_enable),          64'(m_we));
      chk("select",  64'(out_write_register_select), 64'(m_sel));
      chk("data",    64'(out_write_data),            64'(m_data));
      chk("done",    64'(out_init_done),             64'(m_done));
      for (int r = 0; r < NREG; r++)
        if (rf[r] !== exp_rf[r]) chk("regfile", 64'(rf[r]), 64'(exp_rf[r]));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [4:0] s, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_select[5*i +: 5] = s;
    req_data[DW*i +: DW] = d;
  endtask

  int exp_order [6] = '{0, 1, 2, 0, 1, 2};
  int got;
  bit all_zero;
  int waited;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET      = 1'b1;
    req_valid  = '0;
    req_select = '0;
    req_data   = '0;
    for (int r = 0; r < NREG; r++) begin
      rf[r]     = DW'(32'hDEAD_0000 + r);
      exp_rf[r] = DW'(32'hDEAD_0000 + r);
    end
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_enable", 64'(out_write_enable), 64'd0);
    chk("rst_done",   64'(out_init_done),    64'd0);
    chk("rst_ready",  64'(req_ready),        64'd0);
    chk("rst_select", 64'(out_write_register_select), 64'd0);

    // Reset in cycle 10 of INIT
    RESET = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("mid_init_sel", 64'(out_write_register_select), 64'd9);
    #2 RESET = 1'b1;
    #1 chk("mid_init_async_we", 64'(out_write_enable), 64'd0);
    chk("mid_init_async_sel", 64'(out_write_register_select), 64'd0);
    tick();
    RESET = 1'b0;

    // Full sweep
    for (int k = 0; k < NREG; k++) begin
      tick();
      chk("sweep_we",   64'(out_write_enable), 64'd1);
      chk("sweep_sel",  64'(out_write_register_select), 64'(k));
      chk("sweep_data", 64'(out_write_data), 64'd0);
      chk("sweep_done", 64'(out_init_done), 64'(k == NREG - 1));
    end

    // Single write: requester 1 -> x7, ready in the same cycle init_done rises
    set_req(1, 1'b1, 5'd7, DW'(32'h1234_5678));
    #1 chk("single_ready", 64'(req_ready), 64'b010);
    tick();
    set_req(1, 1'b0, 5'd0, '0);
    chk("single_we",   64'(out_write_enable), 64'd1);
    chk("single_sel",  64'(out_write_register_select), 64'd7);
    chk("single_data", 64'(out_write_data), 64'h1234_5678);
    all_zero = 1'b1;
    for (int r = 0; r < NREG; r++) if (rf[r] !== '0) all_zero = 1'b0;
    chk("sweep_all_zero", 64'(all_zero), 64'd1);
    tick();
    chk("single_commit", 64'(rf[7]), 64'h1234_5678);

    // x0 suppression: rr is 2 here
    set_req(2, 1'b1, 5'd0, DW'(32'hFFFF));
    #1 chk("x0_ready", 64'(req_ready), 64'b100);
    tick();
    set_req(2, 1'b0, 5'd0, '0);
    chk("x0_we", 64'(out_write_enable), 64'd0);
    tick();
    chk("x0_reg", 64'(rf[0]), 64'd0);

    // Round robin with all valid; first grant confirms rr wrapped to 0
    set_req(0, 1'b1, 5'd10, DW'(32'hA0));
    set_req(1, 1'b1, 5'd11, DW'(32'hA1));
    set_req(2, 1'b1, 5'd12, DW'(32'hA2));
    for (int i = 0; i < 6; i++) begin
      #1;
      got = -1;
      for (int b = 0; b < NREQ; b++) if (req_ready[b]) got = b;
      chk("rr_grant", 64'(got), 64'(exp_order[i]));
      if (i > 0) chk("rr_no_idle", 64'(out_write_enable), 64'd1);
      tick();
    end
    req_valid = '0;
    chk("rr_last_sel", 64'(out_write_register_select), 64'd12);
    tick();
    chk("rr_x10", 64'(rf[10]), 64'hA0);
    chk("rr_x12", 64'(rf[12]), 64'hA2);

    // Withdrawn request
    set_req(0, 1'b1, 5'd3, DW'(32'h33));
    tick();
    set_req(1, 1'b1, 5'd4, DW'(32'h44));
    #1 chk("wd_grant1", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0;
    chk("wd_sel4", 64'(out_write_register_select), 64'd4);
    tick();
    chk("wd_no_spurious", 64'(out_write_enable), 64'd0);
    set_req(0, 1'b1, 5'd3, DW'(32'h55));
    set_req(2, 1'b1, 5'd5, DW'(32'h66));
    #1 chk("wd_follow_rr", 64'(req_ready), 64'b100);
    tick();
    req_valid = '0;
    tick();

    // Reset right after a transfer in RUN
    set_req(1, 1'b1, 5'd9, DW'(32'hAAAA));
    tick();
    req_valid = '0;
    tick();
    set_req(0, 1'b1, 5'd9, DW'(32'hBBBB));
    tick();
    req_valid = '0;
    chk("run_rst_pre_we", 64'(out_write_enable), 64'd1);
    #2 RESET = 1'b1;
    #1 chk("run_rst_async_we", 64'(out_write_enable), 64'd0);
    chk("run_rst_done", 64'(out_init_done), 64'd0);
    tick();
    chk("run_rst_dropped", 64'(rf[9]), 64'hAAAA);
    RESET = 1'b0;
    tick();
    chk("restart_sel", 64'(out_write_register_select), 64'd0);
    chk("restart_we",  64'(out_write_enable), 64'd1);
    waited = 0;
    while (!out_init_done && waited < 40) begin
      tick();
      waited++;
    end
    chk("restart_done_in_time", 64'(out_init_done), 64'd1);
    tick();
    chk("restart_x9_zero", 64'(rf[9]), 64'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
